// File: rtl/load_ext_pkg.sv
// Shared definitions for the load-data extension path: op codes and buffer sizing.
package load_ext_pkg;

    typedef logic [2:0] ext_op_t;

    localparam ext_op_t EXT_W  = 3'd0;
    localparam ext_op_t EXT_BU = 3'd1;
    localparam ext_op_t EXT_B  = 3'd2;
    localparam ext_op_t EXT_HU = 3'd3;
    localparam ext_op_t EXT_H  = 3'd4;

    localparam int BUF_DEPTH = 2;
    localparam int PTR_W     = $clog2(BUF_DEPTH);

endpackage

// File: rtl/load_ext_sel.sv
// Combinational byte/halfword/word select with sign/zero extension (little-endian).
// The err port exists only when LOAD_EXT_ERR_EN is defined.
module load_ext_sel
    import load_ext_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFF_W-1:0]  in_off,
    input  logic [2:0]        in_op,
    output logic [DATA_W-1:0] data
`ifdef LOAD_EXT_ERR_EN
    ,
    output logic              err
`endif
);

    logic [OFF_W-1:0] off_h;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;

    // Halfword accesses ignore the low offset bit; misalignment is only flagged.
    assign off_h  = {in_off[OFF_W-1:1], 1'b0};
    assign byte_v = 8'(in_data >> {in_off, 3'b000});
    assign half_v = 16'(in_data >> {off_h, 3'b000});

    always_comb begin
        data = in_data;
        case (ext_op_t'(in_op))
            EXT_BU:  data = {{(DATA_W - 8){1'b0}}, byte_v};
            EXT_B:   data = {{(DATA_W - 8){byte_v[7]}}, byte_v};
            EXT_HU:  data = {{(DATA_W - 16){1'b0}}, half_v};
            EXT_H:   data = {{(DATA_W - 16){half_v[15]}}, half_v};
            default: data = in_data;
        endcase
    end

`ifdef LOAD_EXT_ERR_EN
    always_comb begin
        err = 1'b0;
        case (ext_op_t'(in_op))
            EXT_W:          err = (in_off != '0);
            EXT_BU, EXT_B:  err = 1'b0;
            EXT_HU, EXT_H:  err = in_off[0];
            default:        err = 1'b1;
        endcase
    end
`endif

endmodule

// File: rtl/load_ext_pipe.sv
// Load-data extension stage with a 2-entry elastic buffer between memory and writeback.
// Optional LOAD_EXT_ERR_EN builds per-entry misalignment/reserved-op flags.
module load_ext_pipe
    import load_ext_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFF_W-1:0]  in_off,
    input  logic [2:0]        in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] buf_data [BUF_DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [1:0]        count;
    logic              push, pop;

`ifdef LOAD_EXT_ERR_EN
    logic                 sel_err;
    logic [BUF_DEPTH-1:0] buf_err;
`endif

    load_ext_sel #(.DATA_W(DATA_W)) u_sel (
        .in_data (in_data),
        .in_off  (in_off),
        .in_op   (in_op),
        .data    (sel_data)
`ifdef LOAD_EXT_ERR_EN
        ,
        .err     (sel_err)
`endif
    );

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (count != 2'(BUF_DEPTH));
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign out_data  = buf_data[head];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) buf_data[i] <= '0;
        end else if (flush) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (push) begin
                buf_data[tail] <= sel_data;
                tail           <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef LOAD_EXT_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     buf_err       <= '0;
        else if (push) buf_err[tail] <= sel_err;
    end

    assign out_err = buf_err[head];
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_load_ext_pipe.sv
// Randomized scoreboard bench for load_ext_pipe; expected results come from an arithmetic model.
module tb_load_ext_pipe;

    localparam int DW = 32;

`ifdef LOAD_EXT_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic          in_ready, out_valid, out_err;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    in_off;
    logic [2:0]    in_op;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   acc   = 0;
    int   pops  = 0;

    // Directed vectors can override the model with a hand-computed value.
    logic          use_exp = 1'b0;
    logic [DW-1:0] exp_data;
    logic          exp_err;

    load_ext_pipe #(.DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_off(in_off), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pick the addressed field with plain arithmetic, then extend.
    function automatic exp_t model(input logic [DW-1:0] d, input int off, input int op);
        exp_t        r;
        longint      b, h;
        b = (longint'(d) >> (8 * off)) % 256;
        h = (longint'(d) >> (8 * (off - off % 2))) % 65536;
        case (op)
            1:       r.data = DW'(b);
            2:       r.data = DW'(b >= 128 ? b - 256 : b);
            3:       r.data = DW'(h);
            4:       r.data = DW'(h >= 32768 ? h - 65536 : h);
            default: r.data = d;
        endcase
        r.err = ERR_EN && ((op >= 5) || (op == 0 && off != 0) ||
                           ((op == 3 || op == 4) && (off % 2 == 1)));
        return r;
    endfunction

    // Monitor: occupancy, head-entry compare, pop, then record accepted input.
    always @(negedge clk) begin
        if (!reset) begin
            chk("in_ready", in_ready, (q.size() < 2));
            chk("out_valid", out_valid, (q.size() > 0));
            if (out_valid && q.size() > 0) begin
                chk("out_data", out_data, q[0].data);
                chk("out_err", out_err, q[0].err);
                if (out_ready && !flush) begin
                    void'(q.pop_front());
                    pops++;
                end
            end
            if (flush) q.delete();
            else if (in_valid && in_ready) begin
                exp_t e;
                if (use_exp) begin
                    e.data = exp_data;
                    e.err  = exp_err;
                end else e = model(in_data, int'(in_off), int'(in_op));
                q.push_back(e);
                acc++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [DW-1:0] d, input int off, input int op);
        in_valid = 1'b1;
        in_data  = d;
        in_off   = 2'(off);
        in_op    = 3'(op);
    endtask

    // One directed transfer with a constant expectation; waits for acceptance.
    task automatic directed(input logic [DW-1:0] d, input int off, input int op,
                            input logic [DW-1:0] ed, input logic ee);
        use_exp  = 1'b1;
        exp_data = ed;
        exp_err  = ee;
        drive(d, off, op);
        cyc();
        in_valid = 1'b0;
        use_exp  = 1'b0;
        cyc();
    endtask

    task automatic drain(input string name);
        int n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (q.size() != 0 && n < 20) begin
            cyc();
            n++;
        end
        chk(name, 32'(q.size()), 32'd0);
    endtask

    initial begin
        int a0, p0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_off = '0; in_op = '0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_err", out_err, 1'b0);
        #20;
        cyc();
        reset = 1'b0;
        cyc();

        directed(32'h80FF_7F01, 1, 2, 32'h0000_007F, 1'b0);
        directed(32'h80FF_7F01, 3, 2, 32'hFFFF_FF80, 1'b0);
        directed(32'h80FF_7F01, 3, 1, 32'h0000_0080, 1'b0);
        directed(32'h8001_1234, 2, 4, 32'hFFFF_8001, 1'b0);
        directed(32'h8001_1234, 2, 3, 32'h0000_8001, 1'b0);
        directed(32'h8001_1234, 0, 4, 32'h0000_1234, 1'b0);
        directed(32'h8001_1234, 1, 4, 32'h0000_1234, ERR_EN);
        directed(32'hCAFE_F00D, 2, 0, 32'hCAFE_F00D, ERR_EN);
        directed(32'hCAFE_F00D, 0, 6, 32'hCAFE_F00D, ERR_EN);
        drain("drain_directed");

        // Back-pressure: four offered, two accepted.
        out_ready = 1'b0;
        a0 = acc;
        for (int i = 0; i < 4; i++) begin
            drive($urandom, i, 1 + i);
            cyc();
        end
        in_valid = 1'b0;
        chk("bp_accepted", 32'(acc - a0), 32'd2);
        chk("bp_in_ready_low", in_ready, 1'b0);
        drain("drain_bp");

        // Flush with a full buffer, a pending input and out_ready high.
        out_ready = 1'b0;
        drive(32'h1111_2222, 0, 0); cyc();
        drive(32'h3333_4444, 0, 0); cyc();
        p0 = pops;
        flush = 1'b1; out_ready = 1'b1; drive(32'h5555_6666, 0, 0);
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        chk("flush_no_emit", 32'(pops - p0), 32'd0);
        cyc();

        // Random traffic with occasional flushes and reserved ops.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 25) == 0;
            in_data   = $urandom;
            in_off    = 2'($urandom);
            in_op     = 3'($urandom);
            cyc();
        end
        flush = 1'b0;
        drain("drain_random");

        // Asynchronous reset with two entries held.
        out_ready = 1'b0;
        drive($urandom, 0, 0); cyc();
        drive($urandom, 0, 0); cyc();
        in_valid = 1'b0;
        chk("full_before_rst", in_ready, 1'b0);
        #2;
        reset = 1'b1;
        q.delete();
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_out_data", out_data, '0);
        cyc();
        reset = 1'b0;
        out_ready = 1'b1;
        cyc();
        directed(32'h0000_FF00, 1, 2, 32'hFFFF_FFFF, 1'b0);
        drain("drain_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
